// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use stall,
// jump squash and memory-access freeze. Performance counters under PIPE_PERF_CNT_EN.
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic        use_rs1_ID,
   input  logic        use_rs2_ID,
   input  logic [4:0]  rd_EX,
   input  logic        memread_EX,
   input  logic        jump_EX,
   input  logic        mem_req_MEM,
   input  logic        mem_ready,
   output logic        mem_start,
   output logic        stall_PC,
   output logic        stall_IF_ID,
   output logic        stall_ID_EX,
   output logic        stall_EX_MEM,
   output logic        stall_MEM_WB,
   output logic        flush_IF_ID,
   output logic        flush_ID_EX,
   output logic        flush_MEM_WB,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, WAIT, DONE} state_t;

   state_t state;
   logic   load_use;
   logic   freeze;
   logic   jump_flush;
   logic   lu_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (mem_req_MEM) state <= WAIT;
            WAIT:    if (mem_ready)   state <= DONE;
            DONE:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Freeze outranks jump, and jump outranks load-use (ID is on the wrong path).
   always_comb begin
      load_use   = memread_EX && (rd_EX != 5'd0) &&
                   ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                    (use_rs2_ID && (rs2_ID == rd_EX)));
      freeze     = ((state == RUN) && mem_req_MEM) || (state == WAIT);
      jump_flush = !freeze && jump_EX;
      lu_stall   = !freeze && !jump_EX && load_use;
   end

   always_comb begin
      mem_start    = !rst && (state == RUN) && mem_req_MEM;
      stall_PC     = !rst && (freeze || lu_stall);
      stall_IF_ID  = !rst && (freeze || lu_stall);
      stall_ID_EX  = !rst && freeze;
      stall_EX_MEM = !rst && freeze;
      stall_MEM_WB = 1'b0;
      flush_IF_ID  = !rst && jump_flush;
      flush_ID_EX  = !rst && (jump_flush || lu_stall);
      flush_MEM_WB = !rst && freeze;
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (freeze || lu_stall) stall_cnt <= stall_cnt + 32'd1;
         if (jump_flush)         flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand-written handshake
// sequences and a randomized run against a per-register behavioural model.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_ID, rs2_ID, rd_EX;
   logic        use_rs1_ID, use_rs2_ID, memread_EX, jump_EX;
   logic        mem_req_MEM, mem_ready;
   logic        mem_start, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
   logic        stall_MEM_WB, flush_IF_ID, flush_ID_EX, flush_MEM_WB;
   logic [31:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_stall;
   logic [31:0] exp_flush;

   // Output vector order: {start, sPC, sIFID, sIDEX, sEXMEM, sMEMWB, fIFID, fIDEX, fMEMWB}
   localparam logic [8:0] NONE  = 9'b000000000;
   localparam logic [8:0] START = 9'b100000000;
   localparam logic [8:0] FRZ   = 9'b011110001;
   localparam logic [8:0] LU    = 9'b011000010;
   localparam logic [8:0] JMP   = 9'b000000110;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       j;
      logic [8:0] exp;
      string      name;
   } vec_t;

   vec_t vec_q[$];

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .rd_EX(rd_EX), .memread_EX(memread_EX), .jump_EX(jump_EX),
      .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
      .mem_start(mem_start),
      .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
      .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
      .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
      .flush_MEM_WB(flush_MEM_WB),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   function automatic logic [8:0] outVec();
      return {mem_start, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
              stall_MEM_WB, flush_IF_ID, flush_ID_EX, flush_MEM_WB};
   endfunction

   // Counters only exist when the performance option is compiled in.
   function automatic logic [31:0] cntExp(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return (v & 32'd0);
`endif
   endfunction

   function automatic vec_t mkVec(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2,
                                  input logic [4:0] rd, input logic mr,
                                  input logic j, input logic [8:0] e,
                                  input string name);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
      v.mr = mr; v.j = j; v.exp = e; v.name = name;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [4:0] rd, input logic mr,
                                input logic j, input logic mreq,
                                input logic mrdy);
      rs1_ID = rs1; rs2_ID = rs2; use_rs1_ID = u1; use_rs2_ID = u2;
      rd_EX = rd; memread_EX = mr; jump_EX = j;
      mem_req_MEM = mreq; mem_ready = mrdy;
   endtask

   task automatic idle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_stall = 32'd0;
      exp_flush = 32'd0;
   endtask

   // Drive one cycle at the falling edge, check outputs, then let the edge happen.
   task automatic cycleCheck(input string name, input logic [8:0] e);
      #1;
      checkOutput(name, 32'(outVec()), 32'(e));
      exp_stall = exp_stall + 32'(e[7]);
      exp_flush = exp_flush + 32'(e[2]);
      @(posedge clk);
      #1;
   endtask

   // Reference model state: an access outstanding, or the release cycle after it.
   bit busy;
   bit releasing;

   initial begin
      rst = 1'b1;
      idle();
      mem_req_MEM = 1'b1;
      jump_EX = 1'b1;
      #2;
      checkOutput("reset_outputs_forced", 32'(outVec()), 32'(NONE));
      doReset();
      #1;
      checkOutput("post_reset_idle", 32'(outVec()), 32'(NONE));
      checkOutput("post_reset_stall_cnt", stall_cnt, 32'd0);
      checkOutput("post_reset_flush_cnt", flush_cnt, 32'd0);

      vec_q.push_back(mkVec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NONE, "idle"));
      vec_q.push_back(mkVec(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, LU,   "lu_rs1"));
      vec_q.push_back(mkVec(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, NONE, "lu_rd_zero"));
      vec_q.push_back(mkVec(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, LU,   "lu_rs2"));
      vec_q.push_back(mkVec(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, NONE, "lu_unused_src"));
      vec_q.push_back(mkVec(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, NONE, "no_load"));
      vec_q.push_back(mkVec(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, JMP,  "jump_over_lu"));
      vec_q.push_back(mkVec(5'd2, 5'd9, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, JMP,  "jump_alone"));
      vec_q.push_back(mkVec(5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, NONE, "lu_reg_differs"));

      foreach (vec_q[i]) begin
         applyStimulus(vec_q[i].rs1, vec_q[i].rs2, vec_q[i].u1, vec_q[i].u2,
                       vec_q[i].rd, vec_q[i].mr, vec_q[i].j, 1'b0, 1'b0);
         cycleCheck(vec_q[i].name, vec_q[i].exp);
         checkOutput({vec_q[i].name, "_stall_cnt"}, stall_cnt, cntExp(exp_stall));
         checkOutput({vec_q[i].name, "_flush_cnt"}, flush_cnt, cntExp(exp_flush));
         @(negedge clk);
      end

      // Memory handshake: request at cycle 0, ready at cycle 3.
      doReset();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycleCheck("mem_c0", START | FRZ);
      @(negedge clk);
      cycleCheck("mem_c1", FRZ);
      @(negedge clk);
      cycleCheck("mem_c2", FRZ);
      @(negedge clk);
      mem_ready = 1'b1;
      cycleCheck("mem_c3", FRZ);
      @(negedge clk);
      mem_ready = 1'b0;
      cycleCheck("mem_c4_done", NONE);
      @(negedge clk);
      mem_req_MEM = 1'b0;
      cycleCheck("mem_c5_run", NONE);
      checkOutput("mem_stall_cnt", stall_cnt, cntExp(32'd4));

      // Jump held across a freeze only takes effect in the release cycle.
      doReset();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycleCheck("fj_c0", START | FRZ);
      @(negedge clk);
      cycleCheck("fj_c1", FRZ);
      @(negedge clk);
      mem_ready = 1'b1;
      cycleCheck("fj_c2", FRZ);
      @(negedge clk);
      mem_ready = 1'b0;
      cycleCheck("fj_c3_done", JMP);
      checkOutput("fj_flush_cnt", flush_cnt, cntExp(32'd1));

      // Asynchronous reset in the middle of an access.
      doReset();
      applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      cycleCheck("rst_c0", START | FRZ);
      @(negedge clk);
      #1;
      checkOutput("rst_wait_frozen", 32'(outVec()), 32'(FRZ));
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_outputs", 32'(outVec()), 32'(NONE));
      checkOutput("rst_async_stall_cnt", stall_cnt, 32'd0);
      checkOutput("rst_async_flush_cnt", flush_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_stall = 32'd0;
      exp_flush = 32'd0;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycleCheck("rst_stray_ready", NONE);
      @(negedge clk);
      idle();
      cycleCheck("rst_after_stray", NONE);
      @(negedge clk);
      mem_req_MEM = 1'b1;
      cycleCheck("rst_back_in_run", START | FRZ);
      checkOutput("rst_stall_cnt", stall_cnt, cntExp(32'd1));
      checkOutput("rst_flush_cnt", flush_cnt, 32'd0);

`ifdef PIPE_PERF_CNT_EN
      doReset();
      force dut.stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt;
      applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cycleCheck("wrap_lu", LU);
      checkOutput("wrap_stall_cnt", stall_cnt, 32'd0);
`endif

      // Randomized run against the model.
      doReset();
      busy = 1'b0;
      releasing = 1'b0;
      for (int c = 0; c < 400; c++) begin
         logic       frozen, hz, jf, ls, ms;
         logic [8:0] e;
         applyStimulus(5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       5'($urandom_range(3, 0)), ($urandom_range(99, 0) < 50),
                       ($urandom_range(99, 0) < 20), ($urandom_range(99, 0) < 25),
                       ($urandom_range(99, 0) < 30));
         // Which pipeline registers hold or take a bubble this cycle.
         ms     = !busy && !releasing && mem_req_MEM;
         frozen = busy || ms;
         hz     = memread_EX && (rd_EX != 5'd0) &&
                  ((use_rs1_ID && rs1_ID == rd_EX) || (use_rs2_ID && rs2_ID == rd_EX));
         jf     = !frozen && jump_EX;
         ls     = !frozen && !jump_EX && hz;
         e      = {ms, frozen || ls, frozen || ls, frozen, frozen, 1'b0,
                   jf, jf || ls, frozen};
         if (busy) begin
            if (mem_ready) begin
               busy = 1'b0;
               releasing = 1'b1;
            end
         end else if (releasing) begin
            releasing = 1'b0;
         end else if (mem_req_MEM) begin
            busy = 1'b1;
         end
         cycleCheck("random_outputs", e);
         @(negedge clk);
      end
      checkOutput("random_stall_cnt", stall_cnt, cntExp(exp_stall));
      checkOutput("random_flush_cnt", flush_cnt, cntExp(exp_flush));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. Drives the per-stage stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It detects load-use hazards, squashes wrong-path instructions on a taken branch or jump, and freezes the whole pipeline around multi-cycle data-memory accesses through a start/ready handshake. Optional performance counters record stall cycles and flush events.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- rs1_ID  in  5  source register 1 of the instruction in ID
- rs2_ID  in  5  source register 2 of the instruction in ID
- use_rs1_ID  in  1  the ID instruction reads rs1
- use_rs2_ID  in  1  the ID instruction reads rs2
- rd_EX  in  5  destination register of the instruction in EX
- memread_EX  in  1  the EX instruction is a load
- jump_EX  in  1  taken branch or jump resolved in EX
- mem_req_MEM  in  1  the MEM instruction accesses data memory
- mem_ready  in  1  data memory completion, single-cycle pulse
- mem_start  out  1  one-cycle pulse that launches the data-memory access
- stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  out  1 each  hold the register
- flush_IF_ID, flush_ID_EX, flush_MEM_WB  out  1 each  load a bubble (NOP, control 0)
- stall_cnt  out  32  stall-cycle counter (PIPE_PERF_CNT_EN only)
- flush_cnt  out  32  flush-event counter (PIPE_PERF_CNT_EN only)

## Operation
- FSM states: RUN, WAIT, DONE. Reset state is RUN.
- RUN with mem_req_MEM=1:
  - Pulse mem_start.
  - Assert freeze: stall_PC, stall_IF_ID, stall_ID_EX and stall_EX_MEM = 1; flush_MEM_WB = 1.
  - Next state WAIT.
- WAIT: freeze stays asserted. mem_ready=1 gives next state DONE. Otherwise the FSM stays in WAIT with no timeout.
- DONE: no freeze and no mem_start, so the MEM instruction advances. Next state is RUN.
- mem_ready outside WAIT is ignored.
- Load-use hazard is asserted when all of the following hold: memread_EX=1, rd_EX≠0, and either (use_rs1_ID and rs1_ID==rd_EX) or (use_rs2_ID and rs2_ID==rd_EX). Response: stall_PC=1, stall_IF_ID=1, flush_ID_EX=1.
- jump_EX=1 gives flush_IF_ID=1 and flush_ID_EX=1, with no PC stall.
- Priority: freeze > jump > load-use.
  - While frozen, the jump and load-use outputs are suppressed. The EX instruction is held, so they are re-evaluated after release.
  - A jump suppresses the load-use stall, because the ID instruction is on the wrong path.
- Outputs not named above are 0.
- stall_MEM_WB is always 0, reserved.
- A memory op reaching MEM in the DONE cycle is not possible, because EX/MEM was frozen. The next RUN cycle starts its access normally.

## Timing
- stall/flush outputs are combinational from the FSM state and the current inputs, with no added latency.
- mem_start is combinational in the RUN cycle where mem_req_MEM=1.
- Memory-op penalty is 1 + N cycles, where N is the number of WAIT cycles until mem_ready (N≥1). The DONE cycle adds no stall.
- Load-use costs exactly 1 bubble. A taken jump costs 2 bubbles.
- rst is asynchronous: the FSM goes to RUN immediately and the counters clear.
- While rst=1, every stall, flush and mem_start output is forced to 0.
- Reset during WAIT abandons the access. Memory is expected to be reset by the same rst.

## Configuration
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with freeze or load-use stall active.
  - flush_cnt increments on every cycle with jump_EX flushing, not suppressed by freeze.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

## Test plan
- Load-use: memread_EX=1, rd_EX=5, rs1_ID=5, use_rs1_ID=1 → stall_PC=stall_IF_ID=flush_ID_EX=1 for 1 cycle. Repeating with rd_EX=0 → all outputs 0.
- Jump with simultaneous hazard: jump_EX=1 and the load-use condition true → flush_IF_ID=flush_ID_EX=1, stall_PC=0. With the counters enabled, flush_cnt increments by 1.
- Memory handshake: mem_req_MEM=1 at cycle 0, mem_ready pulsed at cycle 3 → mem_start at cycle 0 only; freeze outputs at cycles 0–3; DONE at cycle 4 with all outputs 0; RUN at cycle 5. stall_cnt=4.
- Freeze over jump: jump_EX=1 during WAIT → no flush while frozen; flush_IF_ID/flush_ID_EX asserted in the DONE cycle if jump_EX is still 1.
- Mid-operation reset: rst asserted asynchronously in WAIT → outputs go to 0 immediately. After release, the FSM is in RUN, a stray mem_ready is ignored, and the counters read 0.
- Counter wrap: force stall_cnt to 0xFFFFFFFF, then one stall cycle → stall_cnt reads 0.
